// File: rtl/inference_sorter_if.sv
// Bus bundle for inference_sorter: classified-entry input side plus the
// drained-output handshake and status outputs.
interface inference_sorter_if #(
  parameter int PTR_W  = 2,
  parameter int DROP_W = 8
) ();
  logic [65:0]            entry_in;
  logic                   entry_valid;
  logic                   npu_on;
  logic [63:0]            out_data;
  logic [1:0]             out_class;
  logic                   out_valid;
  logic                   out_rdy;
  logic                   busy;
  logic                   sort_done;
  logic [4*(PTR_W+1)-1:0] class_counts;
  logic [DROP_W-1:0]      drop_count;

  modport slave (
    input  entry_in, entry_valid, npu_on, out_rdy,
    output out_data, out_class, out_valid, busy, sort_done, class_counts, drop_count
  );

  modport master (
    output entry_in, entry_valid, npu_on, out_rdy,
    input  out_data, out_class, out_valid, busy, sort_done, class_counts, drop_count
  );
endinterface

// File: rtl/inference_sorter.sv
// Buckets NPU-classified entries into four per-class FIFOs while the NPU runs,
// then drains them in class order through a registered valid/ready stage.
module inference_sorter #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int DROP_W = 8
) (
  input logic              clk,
  input logic              reset,
  inference_sorter_if.slave bus
);

  localparam int NCLS = 4;
  localparam int AW   = 2 + PTR_W;
  localparam logic [1:0] LAST_CLS = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cur_q, cur_d;
  logic [63:0]       out_data_q, out_data_d;
  logic [1:0]        out_class_q, out_class_d;
  logic              out_valid_q, out_valid_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [NCLS-1:0][PTR_W-1:0] head_vec;
  logic [NCLS-1:0][PTR_W-1:0] tail_vec;
  logic [NCLS-1:0][PTR_W:0]   count_vec;

  logic [63:0] queue_mem [NCLS*DEPTH];

  logic [1:0]  in_class;
  logic [63:0] in_payload;
  logic        take_entry;
  logic        push_en;
  logic        pop_en;
  logic        drop_en;
  logic        cur_empty;
  logic        cur_last;
  logic        beat_free;

  assign in_class   = bus.entry_in[65:64];
  assign in_payload = bus.entry_in[63:0];
  assign cur_empty  = (count_vec[cur_q] == '0);
  assign cur_last   = (count_vec[cur_q] == (PTR_W+1)'(1));
  // The output register may take a new beat when it is empty or being accepted.
  assign beat_free  = !out_valid_q || bus.out_rdy;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    out_data_d  = out_data_q;
    out_class_d = out_class_q;
    out_valid_d = out_valid_q;
    take_entry  = 1'b0;
    push_en     = 1'b0;
    pop_en      = 1'b0;
    drop_en     = 1'b0;

    if (out_valid_q && bus.out_rdy) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.npu_on) begin
          state_d    = S_COLLECT;
          take_entry = bus.entry_valid;
        end
      end
      S_COLLECT: begin
        take_entry = bus.entry_valid;
        if (!bus.npu_on) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drop_en = bus.entry_valid;
        if (!cur_empty) begin
          if (beat_free) begin
            pop_en      = 1'b1;
            out_data_d  = queue_mem[{cur_q, head_vec[cur_q]}];
            out_class_d = cur_q;
            out_valid_d = 1'b1;
            if (cur_last && (cur_q != LAST_CLS)) begin
              cur_d = cur_q + 2'd1;
            end
          end
        end else if (cur_q != LAST_CLS) begin
          cur_d = cur_q + 2'd1;
        end else if (beat_free) begin
          // Scan order guarantees every earlier class is already empty here.
          state_d     = S_DONE;
          cur_d       = 2'd0;
          out_valid_d = 1'b0;
        end
      end
      S_DONE: begin
        cur_d   = 2'd0;
        state_d = bus.npu_on ? S_COLLECT : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (take_entry) begin
      if (count_vec[in_class][PTR_W]) begin
        drop_en = 1'b1;
      end else begin
        push_en = 1'b1;
      end
    end

    drop_d = drop_q;
    if (drop_en && (drop_q != '1)) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cur_q       <= 2'd0;
      out_data_q  <= '0;
      out_class_q <= 2'd0;
      out_valid_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      out_data_q  <= out_data_d;
      out_class_q <= out_class_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
    end
  end

  // Payload storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_en) begin
      queue_mem[AW'({in_class, tail_vec[in_class]})] <= in_payload;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCLS; gi++) begin : g_cls
      logic [PTR_W-1:0] head_q, head_d;
      logic [PTR_W-1:0] tail_q, tail_d;
      logic [PTR_W:0]   count_q, count_d;
      logic             push_hit;
      logic             pop_hit;

      assign push_hit = push_en && (in_class == 2'(gi));
      assign pop_hit  = pop_en && (cur_q == 2'(gi));

      always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_hit) begin
          tail_d  = tail_q + PTR_W'(1);
          count_d = count_q + (PTR_W+1)'(1);
        end
        if (pop_hit) begin
          head_d  = head_q + PTR_W'(1);
          count_d = count_q - (PTR_W+1)'(1);
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          head_q  <= '0;
          tail_q  <= '0;
          count_q <= '0;
        end else begin
          head_q  <= head_d;
          tail_q  <= tail_d;
          count_q <= count_d;
        end
      end

      assign head_vec[gi]  = head_q;
      assign tail_vec[gi]  = tail_q;
      assign count_vec[gi] = count_q;
    end
  endgenerate

  assign bus.out_data     = out_data_q;
  assign bus.out_class    = out_class_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.busy         = (state_q == S_COLLECT) || (state_q == S_DRAIN);
  assign bus.sort_done    = (state_q == S_DONE);
  assign bus.class_counts = count_vec;
  assign bus.drop_count   = drop_q;

endmodule

// File: tb/tb_inference_sorter.sv
// Directed bench for inference_sorter: stimulus pushes hand-sorted expected
// beats into a queue, a negedge monitor pops and compares accepted beats.
module tb_inference_sorter;

  typedef struct packed {
    logic [1:0]  cls;
    logic [63:0] data;
  } beat_t;

  logic clk;
  logic reset_n;
  int   n_pass;
  int   n_total;
  int   done_pulses;
  beat_t exp_q[$];

  inference_sorter_if #(.PTR_W(2), .DROP_W(8)) bus_if ();

  inference_sorter #(.DEPTH(4), .PTR_W(2), .DROP_W(8)) dut (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] cls, input logic [63:0] data);
    bus_if.entry_in    = {cls, data};
    bus_if.entry_valid = 1'b1;
    step(1);
    bus_if.entry_valid = 1'b0;
  endtask

  task automatic expect_beat(input logic [1:0] cls, input logic [63:0] data);
    beat_t b;
    b.cls  = cls;
    b.data = data;
    exp_q.push_back(b);
  endtask

  task automatic wait_out_valid(input string name, input int budget);
    int n = 0;
    while (!bus_if.out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {63'd0, bus_if.out_valid}, 64'd1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      seen = bus_if.sort_done;
      n++;
    end
    check(name, {63'd0, seen}, 64'd1);
    step(2);
  endtask

  // Monitor: one accepted beat per negedge where valid and ready are both high.
  always @(negedge clk) begin
    if (reset_n && bus_if.out_valid && bus_if.out_rdy) begin
      $display("beat class=%0d data=%h", bus_if.out_class, bus_if.out_data);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL beat_unexpected: got class=%0d data=%h expected no beat",
                 bus_if.out_class, bus_if.out_data);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check("beat_data", bus_if.out_data, b.data);
        check("beat_class", {62'd0, bus_if.out_class}, {62'd0, b.cls});
      end
    end
    if (bus_if.sort_done) begin
      done_pulses++;
    end
  end

  initial begin
    int busy_cycles;
    int ov_cycles;
    int k;
    logic seen;

    clk = 1'b0;
    reset_n = 1'b0;
    n_pass = 0;
    n_total = 0;
    done_pulses = 0;
    bus_if.entry_in = '0;
    bus_if.entry_valid = 1'b0;
    bus_if.npu_on = 1'b0;
    bus_if.out_rdy = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
    check("rst_out_data", bus_if.out_data, 64'd0);
    check("rst_busy", {63'd0, bus_if.busy}, 64'd0);
    check("rst_sort_done", {63'd0, bus_if.sort_done}, 64'd0);
    check("rst_drop_count", {56'd0, bus_if.drop_count}, 64'd0);
    check("rst_class_counts", {52'd0, bus_if.class_counts}, 64'd0);
    step(1);
    reset_n = 1'b1;
    step(1);

    // Basic sort: classes 2,0,1,0 -> B(0) D(0) C(1) A(2)
    done_pulses = 0;
    expect_beat(2'd0, 64'h0000_0000_0000_000B);
    expect_beat(2'd0, 64'h0000_0000_0000_000D);
    expect_beat(2'd1, 64'h0000_0000_0000_000C);
    expect_beat(2'd2, 64'h0000_0000_0000_000A);
    bus_if.npu_on = 1'b1;
    step(1);
    check("t1_busy_collect", {63'd0, bus_if.busy}, 64'd1);
    push(2'd2, 64'h0000_0000_0000_000A);
    push(2'd0, 64'h0000_0000_0000_000B);
    push(2'd1, 64'h0000_0000_0000_000C);
    push(2'd0, 64'h0000_0000_0000_000D);
    check("t1_class_counts", {52'd0, bus_if.class_counts}, 64'h04A);
    bus_if.npu_on = 1'b0;
    bus_if.out_rdy = 1'b1;
    step(1);
    check("t1_drain_no_valid_yet", {63'd0, bus_if.out_valid}, 64'd0);
    step(1);
    check("t1_first_valid", {63'd0, bus_if.out_valid}, 64'd1);
    check("t1_first_data", bus_if.out_data, 64'h0000_0000_0000_000B);
    wait_done("t1_done", 40);
    step(2);
    check("t1_done_pulses", 64'(done_pulses), 64'd1);
    check("t1_drop_count", {56'd0, bus_if.drop_count}, 64'd0);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t1_idle", {63'd0, bus_if.busy}, 64'd0);

    // Overflow: 6 class-3 entries, 4 kept, 2 dropped
    for (int i = 0; i < 4; i++) expect_beat(2'd3, 64'h3300_0000_0000_0000 + 64'(i));
    bus_if.npu_on = 1'b1;
    step(1);
    for (int i = 0; i < 6; i++) push(2'd3, 64'h3300_0000_0000_0000 + 64'(i));
    check("t2_class_counts", {52'd0, bus_if.class_counts}, 64'h800);
    check("t2_drop_count", {56'd0, bus_if.drop_count}, 64'd2);
    bus_if.npu_on = 1'b0;
    wait_done("t2_done", 40);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: 3 class-1 entries, stall 5 cycles
    bus_if.out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) expect_beat(2'd1, 64'h1100_0000_0000_0000 + 64'(i));
    bus_if.npu_on = 1'b1;
    step(1);
    for (int i = 0; i < 3; i++) push(2'd1, 64'h1100_0000_0000_0000 + 64'(i));
    bus_if.npu_on = 1'b0;
    wait_out_valid("t3_valid_rises", 20);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("t3_stall_data", bus_if.out_data, 64'h1100_0000_0000_0000);
      check("t3_stall_valid", {63'd0, bus_if.out_valid}, 64'd1);
    end
    bus_if.out_rdy = 1'b1;
    step(1);
    check("t3_second_data", bus_if.out_data, 64'h1100_0000_0000_0001);
    step(1);
    check("t3_third_data", bus_if.out_data, 64'h1100_0000_0000_0002);
    check("t3_third_valid", {63'd0, bus_if.out_valid}, 64'd1);
    wait_done("t3_done", 40);
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // Empty frame: 1 collect + 4 drain busy cycles, no beat
    done_pulses = 0;
    bus_if.npu_on = 1'b1;
    step(1);
    bus_if.npu_on = 1'b0;
    busy_cycles = 0;
    ov_cycles = 0;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      seen = bus_if.sort_done;
      if (bus_if.busy) busy_cycles++;
      if (bus_if.out_valid) ov_cycles++;
      k++;
    end
    check("t4_done_seen", {63'd0, seen}, 64'd1);
    check("t4_busy_cycles", 64'(busy_cycles), 64'd5);
    check("t4_out_valid_cycles", 64'(ov_cycles), 64'd0);
    step(3);
    check("t4_done_pulses", 64'(done_pulses), 64'd1);

    // Boundary: entry coincident with npu_on fall accepted; entry in DRAIN dropped
    expect_beat(2'd0, 64'h0000_0000_0000_0E0E);
    expect_beat(2'd2, 64'h0000_0000_0000_0D0D);
    bus_if.npu_on = 1'b1;
    step(1);
    push(2'd2, 64'h0000_0000_0000_0D0D);
    bus_if.npu_on = 1'b0;
    push(2'd0, 64'h0000_0000_0000_0E0E);
    push(2'd1, 64'h0000_0000_0000_0F0F);
    wait_done("t5_done", 40);
    check("t5_drop_count", {56'd0, bus_if.drop_count}, 64'd3);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // Drop counter saturation: fill class 0, then 300 forced drops
    for (int i = 0; i < 4; i++) expect_beat(2'd0, 64'h5A00_0000_0000_0000 + 64'(i));
    bus_if.npu_on = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) push(2'd0, 64'h5A00_0000_0000_0000 + 64'(i));
    for (int i = 0; i < 200; i++) push(2'd0, 64'hDEAD_0000_0000_0000 + 64'(i));
    check("t6_drop_mid", {56'd0, bus_if.drop_count}, 64'd203);
    for (int i = 200; i < 300; i++) push(2'd0, 64'hDEAD_0000_0000_0000 + 64'(i));
    check("t6_drop_sat", {56'd0, bus_if.drop_count}, 64'd255);
    bus_if.npu_on = 1'b0;
    wait_done("t6_done", 40);
    check("t6_drop_sat_after", {56'd0, bus_if.drop_count}, 64'd255);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-drain while a beat is held
    bus_if.out_rdy = 1'b0;
    bus_if.npu_on = 1'b1;
    step(1);
    for (int i = 0; i < 3; i++) push(2'd2, 64'h2200_0000_0000_0000 + 64'(i));
    bus_if.npu_on = 1'b0;
    wait_out_valid("t7_valid_rises", 20);
    step(1);
    reset_n = 1'b0;
    #1;
    check("t7_rst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
    check("t7_rst_out_data", bus_if.out_data, 64'd0);
    check("t7_rst_out_class", {62'd0, bus_if.out_class}, 64'd0);
    check("t7_rst_busy", {63'd0, bus_if.busy}, 64'd0);
    check("t7_rst_drop", {56'd0, bus_if.drop_count}, 64'd0);
    step(1);
    reset_n = 1'b1;
    step(2);
    check("t7_idle_busy", {63'd0, bus_if.busy}, 64'd0);
    check("t7_class_counts", {52'd0, bus_if.class_counts}, 64'd0);
    check("t7_out_valid", {63'd0, bus_if.out_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inference_sorter.md
Name: inference_sorter

Overview:
- Sits directly downstream of the NPU pipeline stage.
- Consumes 66-bit classified entries ({inference[1:0], data[63:0]}) together with the valid and NPU_on indicators that stage produces.
- While the NPU runs, it buckets entries into four per-class queues. When NPU_on drops, it drains all queued entries in class order (0,1,2,3), FIFO within each class, over a valid/ready handshake.
- It must finish draining within the NPU's off window and then signal done.

Parameters:
- DEPTH, 4, entries per class queue (power of 2, ≥2).
- PTR_W, 2, log2(DEPTH).
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- entry_in  input  66  classified entry; [65:64] class, [63:0] payload
- entry_valid  input  1  entry_in valid this cycle (single-cycle pulses)
- npu_on  input  1  high while the NPU stage is producing entries
- out_data  output  64  drained payload
- out_class  output  2  class of out_data
- out_valid  output  1  out_data/out_class valid
- out_rdy  input  1  downstream accepts when out_valid && out_rdy
- busy  output  1  high in COLLECT or DRAIN
- sort_done  output  1  one-cycle pulse when drain completes
- class_counts  output  4*(PTR_W+1)  live occupancy per class, class0 in LSBs
- drop_count  output  DROP_W  saturating count of dropped entries

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE; all queue pointers/counts=0; cur_class=0.
  - out_data=0, out_class=0, out_valid=0, busy=0, sort_done=0, drop_count=0.
  - Buffer contents are don't-care.
  - A reset mid-drain abandons all queued entries; no partial output is retained.
- States: IDLE, COLLECT, DRAIN, DONE.
- IDLE:
  - npu_on=1 → COLLECT next cycle.
  - entry_valid in the same cycle is accepted.
  - entry_valid with npu_on=0 is ignored and not counted.
- COLLECT:
  - Each entry_valid writes the payload to queue[class] tail; count[class]+1 next cycle.
  - If count[class]==DEPTH, the entry is dropped and drop_count increments, saturating at 2^DROP_W-1.
  - npu_on sampled 0 → DRAIN next cycle. An entry_valid in that same cycle is still accepted.
- DRAIN:
  - Scan class cur_class, starting at 0.
  - Empty class: advance cur_class next cycle, costing 1 cycle per empty class.
  - Registered output stage: when out_valid=0 or (out_valid && out_rdy), pop the head of queue[cur_class] into out_data/out_class and set out_valid=1.
  - Otherwise hold out_data/out_class/out_valid stable.
  - After the last pop of a class, advance cur_class.
  - When all classes are empty and the final beat has been accepted (or no beat is pending), go to DONE. out_valid=0 on that edge if the final beat has been accepted.
  - entry_valid during DRAIN drops the entry and increments drop_count. npu_on rising during DRAIN is ignored until DONE.
- DONE:
  - sort_done=1 for exactly one cycle, cur_class=0.
  - Next state: COLLECT if npu_on=1, else IDLE.
- Latency:
  - npu_on sampled 0 at edge N in COLLECT → DRAIN at N+1.
  - If class 0 is non-empty, out_valid=1 at N+2.
  - Entries stream at 1/cycle while out_rdy=1, excluding 1-cycle class-skip gaps.
- Simultaneous pop and push cannot occur: pushes happen only in COLLECT, pops only in DRAIN.
- Pointers wrap modulo DEPTH. count is PTR_W+1 bits, so full=DEPTH and empty=0.
- busy=1 in COLLECT and DRAIN; 0 in IDLE and DONE.
- drop_count persists across frames, cleared only by reset.

Test Plan:
- Basic sort: npu_on=1; push classes 2,0,1,0 with payloads A,B,C,D; drop npu_on; out_rdy=1 → outputs B(0), D(0), C(1), A(2); sort_done pulses once; drop_count=0.
- Overflow: push 6 entries of class 3 (DEPTH=4) → class_counts[3]=4, drop_count=2; drain emits the first 4 payloads in order.
- Backpressure: 3 class-1 entries, out_rdy held 0 for 5 cycles after out_valid rises → out_data stays equal to the first payload; releasing out_rdy drains the remaining two on consecutive cycles.
- Empty frame: npu_on 1→0 with no entries → DRAIN scans 4 cycles, sort_done pulses, out_valid never asserts.
- Boundary timing:
  - entry_valid coincident with the npu_on falling cycle is accepted and output.
  - entry_valid during DRAIN is dropped: drop_count +1.
  - drop_count saturates at 255 after 300 forced drops.
- Reset mid-drain: assert reset low while out_valid=1 → all outputs 0 immediately; after release, state is IDLE and class_counts=0.
